// File: rtl/adc_spi_responder_if.sv
// Sample stream, SPI pins and frame status of one emulated serial ADC channel.
interface adc_spi_responder_if #(
  parameter int unsigned DATA_W = 22
);
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              sample_ready;
  logic              spi_cs_pin;
  logic              spi_clk_pin;
  logic              spi_miso_pin;
  logic              frame_done;
  logic              frame_abort;
  logic              stale;

  modport master (
    output sample_data, sample_valid, spi_cs_pin, spi_clk_pin,
    input  sample_ready, spi_miso_pin, frame_done, frame_abort, stale
  );

  modport slave (
    input  sample_data, sample_valid, spi_cs_pin, spi_clk_pin,
    output sample_ready, spi_miso_pin, frame_done, frame_abort, stale
  );
endinterface

// File: rtl/adc_spi_responder.sv
// SPI-slave emulator of a 22-bit serial ADC: serves parallel samples MSB-first after two
// zero lead bits. Define ADC_DRDY_EN to wait (MISO busy-high) for a fresh sample instead of repeating.
module adc_spi_responder #(
  parameter int unsigned DATA_W    = 22,
  parameter int unsigned LEAD_BITS = 2
) (
  input logic                clk,
  input logic                rst,
  adc_spi_responder_if.slave bus
);
  localparam int unsigned FRAME_BITS = LEAD_BITS + DATA_W;
  localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    SHIFT,
    DONE,
    WAIT_RDY,
    DRDY
  } state_t;

  state_t state, state_nx;

  logic cs_meta, cs_sync, cs_prev;
  logic sck_meta, sck_sync, sck_prev;
  logic cs_fall, cs_rise, sck_rise, sck_fall;

  logic                  hold_full;
  logic [DATA_W-1:0]     hold;
  logic [DATA_W-1:0]     last;
  logic [FRAME_BITS-1:0] shift_reg;
  logic [CNT_W-1:0]      bit_cnt;
  logic                  stale_q, done_q, abort_q;

  logic accept, load_go, use_hold, done_evt, abort_evt, miso;

  // CS idles high out of reset so a pin held low produces a clean falling edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cs_meta  <= 1'b1;
      cs_sync  <= 1'b1;
      cs_prev  <= 1'b1;
      sck_meta <= 1'b0;
      sck_sync <= 1'b0;
      sck_prev <= 1'b0;
    end else begin
      cs_meta  <= bus.spi_cs_pin;
      cs_sync  <= cs_meta;
      cs_prev  <= cs_sync;
      sck_meta <= bus.spi_clk_pin;
      sck_sync <= sck_meta;
      sck_prev <= sck_sync;
    end
  end

  assign cs_fall  = cs_prev & ~cs_sync;
  assign cs_rise  = ~cs_prev & cs_sync;
  assign sck_rise = ~sck_prev & sck_sync;
  assign sck_fall = sck_prev & ~sck_sync;
  assign accept   = bus.sample_valid & ~hold_full;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    load_go   = 1'b0;
    use_hold  = 1'b0;
    done_evt  = 1'b0;
    abort_evt = 1'b0;
    case (state)
      IDLE: begin
        if (cs_fall) begin
`ifdef ADC_DRDY_EN
          if (hold_full) begin
            state_nx = LOAD;
            load_go  = 1'b1;
            use_hold = 1'b1;
          end else begin
            state_nx = WAIT_RDY;
          end
`else
          state_nx = LOAD;
          load_go  = 1'b1;
          use_hold = hold_full;
`endif
        end
      end
      WAIT_RDY: begin
        if (cs_rise)        state_nx = IDLE;
        else if (hold_full) state_nx = DRDY;
      end
      DRDY: begin
        if (cs_rise) begin
          state_nx = IDLE;
        end else begin
          state_nx = LOAD;
          load_go  = 1'b1;
          use_hold = 1'b1;
        end
      end
      LOAD: begin
        if (cs_rise) begin
          state_nx  = IDLE;
          abort_evt = 1'b1;
        end else begin
          state_nx = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise) begin
          state_nx  = IDLE;
          abort_evt = 1'b1;
        end else if (sck_rise && bit_cnt == CNT_W'(FRAME_BITS - 1)) begin
          state_nx = DONE;
          done_evt = 1'b1;
        end
      end
      DONE: begin
        if (cs_rise) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    miso = 1'b1;
    if (!cs_sync) begin
      case (state)
        LOAD, SHIFT: miso = shift_reg[FRAME_BITS-1];
        DONE, DRDY:  miso = 1'b0;
        default:     miso = 1'b1;
      endcase
    end
  end

  // A load landing on the CS-fall cycle only fills hold; the frame was already decided.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_full <= 1'b0;
      hold      <= '0;
      last      <= '0;
      shift_reg <= '0;
      bit_cnt   <= '0;
      stale_q   <= 1'b0;
      done_q    <= 1'b0;
      abort_q   <= 1'b0;
    end else begin
      done_q  <= done_evt;
      abort_q <= abort_evt;

      if (use_hold) begin
        hold_full <= 1'b0;
      end else if (accept) begin
        hold_full <= 1'b1;
        hold      <= bus.sample_data;
      end

      if (load_go) begin
        if (use_hold) begin
          shift_reg <= {{LEAD_BITS{1'b0}}, hold};
          last      <= hold;
          stale_q   <= 1'b0;
        end else begin
          shift_reg <= {{LEAD_BITS{1'b0}}, last};
          stale_q   <= 1'b1;
        end
      end else if (state == SHIFT && sck_fall) begin
        shift_reg <= {shift_reg[FRAME_BITS-2:0], 1'b0};
      end

      if (cs_fall || load_go)           bit_cnt <= '0;
      else if (state == SHIFT && sck_rise) bit_cnt <= bit_cnt + 1'b1;
    end
  end

  assign bus.sample_ready = ~hold_full;
  assign bus.spi_miso_pin = miso;
  assign bus.frame_done   = done_q;
  assign bus.frame_abort  = abort_q;
  assign bus.stale        = stale_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Randomized scoreboard bench for adc_spi_responder: each frame is predicted from a small
// hold/last/stale model and compared against the MISO bits the emulated master clocked in.
`timescale 1ns/1ps
module tb_adc_spi_responder;
  localparam int unsigned DATA_W     = 22;
  localparam int          FRAME_BITS = 24;

  typedef struct {
    bit                    abort;
    logic [FRAME_BITS-1:0] word;
    int                    nbits;
    logic                  stale;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  adc_spi_responder_if #(.DATA_W(DATA_W)) bus ();
  adc_spi_responder #(.DATA_W(DATA_W), .LEAD_BITS(2)) dut (.clk(clk), .rst(rst), .bus(bus));

  int   checks    = 0;
  int   failures  = 0;
  exp_t exp_q[$];
  logic rx_bits [0:4095];
  int   edge_cnt  = 0;
  int   base      = 0;
  int   done_seen = 0;
  int   done_exp  = 0;

  logic              model_full = 1'b0;
  logic [DATA_W-1:0] model_hold = '0;
  logic [DATA_W-1:0] model_last = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] got_bits(input int from, input int upto);
    logic [31:0] v = '0;
    for (int i = from; i < upto; i++) v = {v[30:0], rx_bits[i % 4096]};
    return v;
  endfunction

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DATA_W-1:0] d);
    check("ready_before_load", 32'(bus.sample_ready), 32'd1);
    bus.sample_data  = d;
    bus.sample_valid = 1'b1;
    tick(1);
    bus.sample_valid = 1'b0;
    model_hold = d;
    model_full = 1'b1;
    check("ready_after_load", 32'(bus.sample_ready), 32'd0);
  endtask

  // Model rule: the frame is fixed at CS fall; a load on that same cycle is for the next frame.
  task automatic frame_begin(input bit late, input logic [DATA_W-1:0] d, input int nbits);
    exp_t e;
    bus.spi_cs_pin = 1'b0;
    if (model_full) begin
      e.word     = {2'b00, model_hold};
      e.stale    = 1'b0;
      model_last = model_hold;
      model_full = 1'b0;
    end else begin
      e.word  = {2'b00, model_last};
      e.stale = 1'b1;
    end
    e.nbits = nbits;
    e.abort = (nbits < FRAME_BITS);
    exp_q.push_back(e);
    if (!e.abort) done_exp++;
    if (late) begin
      tick(2);
      bus.sample_data  = d;
      bus.sample_valid = 1'b1;
      tick(1);
      bus.sample_valid = 1'b0;
      model_hold = d;
      model_full = 1'b1;
      tick(5);
    end else begin
      tick(8);
    end
    check("ready_after_cs_fall", 32'(bus.sample_ready), 32'(!model_full));
  endtask

  task automatic spi_bits(input int n);
    for (int i = 0; i < n; i++) begin
      bus.spi_clk_pin = 1'b1;
      tick(4);
      bus.spi_clk_pin = 1'b0;
      tick(4);
    end
  endtask

  task automatic frame_end(input int nbits);
    if (nbits == FRAME_BITS) check("miso_low_after_frame", 32'(bus.spi_miso_pin), 32'd0);
    bus.spi_cs_pin = 1'b1;
    tick(4);
    check("miso_high_cs_high", 32'(bus.spi_miso_pin), 32'd1);
    tick(4);
  endtask

  task automatic run_frame(input int nbits);
    frame_begin(1'b0, '0, nbits);
    spi_bits(nbits);
    frame_end(nbits);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_miso", 32'(bus.spi_miso_pin), 32'd1);
    check("rst_ready", 32'(bus.sample_ready), 32'd1);
    check("rst_done", 32'(bus.frame_done), 32'd0);
    check("rst_abort", 32'(bus.frame_abort), 32'd0);
    check("rst_stale", 32'(bus.stale), 32'd0);
    bus.spi_cs_pin   = 1'b1;
    bus.spi_clk_pin  = 1'b0;
    bus.sample_valid = 1'b0;
    foreach (exp_q[i]) if (!exp_q[i].abort) done_exp--;
    exp_q.delete();
    model_full = 1'b0;
    model_last = '0;
    tick(3);
    rst = 1'b0;
    tick(2);
  endtask

  initial begin
    bus.spi_cs_pin   = 1'b1;
    bus.spi_clk_pin  = 1'b0;
    bus.sample_valid = 1'b0;
    bus.sample_data  = '0;

    fork
      forever begin
        @(posedge bus.spi_clk_pin);
        if (!bus.spi_cs_pin) begin
          rx_bits[edge_cnt % 4096] = bus.spi_miso_pin;
          edge_cnt++;
        end
      end
      forever begin
        exp_t e;
        int   n;
        @(negedge clk);
        if (rst) begin
          base = edge_cnt;
        end else if (bus.frame_done || bus.frame_abort) begin
          if (bus.frame_done) done_seen++;
          n = edge_cnt - base;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_frame_event: got done=%0b abort=%0b expected no event",
                     bus.frame_done, bus.frame_abort);
          end else begin
            e = exp_q.pop_front();
            check("event_is_abort", 32'(bus.frame_abort), 32'(e.abort));
            check("bit_count", 32'(n), 32'(e.nbits));
            check("stale", 32'(bus.stale), 32'(e.stale));
            check("frame_bits", got_bits(base, edge_cnt),
                  32'(e.word) >> (FRAME_BITS - e.nbits));
          end
          base = edge_cnt;
        end
      end
      begin
        #5ms;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
      end
    join_none

    tick(1);
    do_reset();

`ifdef ADC_DRDY_EN
    begin
      exp_t e;
      int   busy_err = 0;
      int   w        = 0;
      bus.spi_cs_pin = 1'b0;
      for (int i = 0; i < 50; i++) begin
        tick(1);
        if (bus.spi_miso_pin !== 1'b1) busy_err++;
      end
      check("drdy_busy_high", 32'(busy_err), 32'd0);
      bus.sample_data  = 22'h155555;
      bus.sample_valid = 1'b1;
      tick(1);
      bus.sample_valid = 1'b0;
      while (bus.spi_miso_pin !== 1'b0 && w < 20) begin
        tick(1);
        w++;
      end
      check("drdy_ready_low", 32'(bus.spi_miso_pin), 32'd0);
      e.abort = 1'b0;
      e.word  = {2'b00, 22'h155555};
      e.nbits = FRAME_BITS;
      e.stale = 1'b0;
      exp_q.push_back(e);
      done_exp++;
      tick(6);
      spi_bits(FRAME_BITS);
      frame_end(FRAME_BITS);
      bus.spi_cs_pin = 1'b0;
      tick(20);
      check("drdy_wait_again", 32'(bus.spi_miso_pin), 32'd1);
      check("drdy_never_stale", 32'(bus.stale), 32'd0);
      bus.spi_cs_pin = 1'b1;
      tick(8);
    end
`else
    load(22'h2AAAAA);
    run_frame(FRAME_BITS);
    run_frame(FRAME_BITS);
    load(22'h000001);
    run_frame(FRAME_BITS);

    load(DATA_W'($urandom));
    frame_begin(1'b0, '0, 10);
    spi_bits(10);
    frame_end(10);
    run_frame(FRAME_BITS);

    frame_begin(1'b1, 22'h3FFFFF, FRAME_BITS);
    spi_bits(FRAME_BITS);
    frame_end(FRAME_BITS);
    run_frame(FRAME_BITS);

    load(22'h0F0F0F);
    frame_begin(1'b0, '0, FRAME_BITS);
    spi_bits(5);
    load(22'h123456);
    spi_bits(7);
    do_reset();
    run_frame(FRAME_BITS);

    for (int i = 0; i < 16; i++) begin
      int n;
      bit late;
      if ($urandom_range(0, 1) == 1 && !model_full) load(DATA_W'($urandom));
      n    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 23)) : FRAME_BITS;
      late = (!model_full && $urandom_range(0, 3) == 0);
      frame_begin(late, DATA_W'($urandom), n);
      spi_bits(n);
      frame_end(n);
      tick(int'($urandom_range(0, 5)));
    end
`endif

    tick(10);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("done_pulses", 32'(done_seen), 32'(done_exp));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Synthesizable emulator of one 22-bit serial ADC, i.e. the slave end of the meter's voltage/current SPI read link (CS, serial clock and MISO pins).
- Takes parallel samples from a stimulus source and shifts them out MSB-first when the meter master asserts CS and toggles its clock.
- Used for on-chip loopback of the meter datapath, with one instance per channel (voltage0, current0).

Parameters:
- DATA_W, 22, sample width in bits.
- LEAD_BITS, 2, overflow/status bits sent before the sample, always 0 in this block.
- FRAME_BITS, LEAD_BITS+DATA_W, total bits per read frame (derived, not overridable).

Ports:
- clk  in  1  system clock; meter clock must be at most clk/4.
- rst  in  1  reset.
- sample_data  in  DATA_W  next sample to serve.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  holding register empty; the sample is accepted when valid&&ready.
- spi_cs_pin  in  1  chip select from the master, active low.
- spi_clk_pin  in  1  serial clock from the master; the master samples MISO on the rising edge.
- spi_miso_pin  out  1  serial data to the master.
- frame_done  out  1  one-clk pulse when a full frame has been clocked.
- frame_abort  out  1  one-clk pulse when CS rises mid-frame.
- stale  out  1  the current or last frame repeated the previous sample because no new one was loaded.

Interface: one clock `clk`; `rst` is asynchronous and active-high.

Behaviour:
- Reset values: sample_ready=1, spi_miso_pin=1, frame_done=0, frame_abort=0, stale=0. Holding register empty, last-sent register 0, state IDLE.
- Pin synchronisation: spi_cs_pin and spi_clk_pin each pass through 2-flop synchronisers, then a registered edge detect. Pin-to-action latency is 3 clk.
- Holding register: sample_ready = !hold_full. When valid&&ready, hold_full<=1 on the next clk.
- IDLE → LOAD when synchronised CS falls.
  - If hold_full: shift_reg <= {LEAD_BITS zeros, hold}, last <= hold, hold_full<=0, stale<=0.
  - Otherwise: shift_reg <= {zeros, last}, stale<=1.
  - If a load arrives in the same cycle as the CS fall, that load goes to the holding register for the next frame. It is not used for the current frame.
- LOAD → SHIFT one clk later. spi_miso_pin = shift_reg MSB, valid before the first rising edge.
- SHIFT:
  - Each synchronised clock falling edge shifts shift_reg left by 1 (zero fill).
  - Each rising edge increments bit_cnt.
  - When bit_cnt reaches FRAME_BITS: pulse frame_done and go to DONE.
- DONE: spi_miso_pin=0 until CS rises, then IDLE.
- CS rise in LOAD or SHIFT before FRAME_BITS rising edges:
  - Pulse frame_abort and go to IDLE.
  - The sample counts as consumed; last keeps it.
- spi_miso_pin=1 whenever synchronised CS is high.
- Clock edges while CS is high are ignored. bit_cnt clears on every CS fall.
- Asynchronous rst mid-frame: immediate return to reset values, and any held sample is discarded.

Optional Feature:
- Macro: ADC_DRDY_EN.
- With the macro: while CS is low and hold_full=0, the block stays in IDLE-wait with spi_miso_pin=1 (busy). It does not use the stale sample. When a sample is loaded during that CS-low window, the block drives spi_miso_pin=0 (data ready) for 1 clk-synchronised cycle, then performs the LOAD action as if CS had just fallen. stale is never set.
- Without the macro: stale-repeat behaviour as described above.

Test Plan:
- Load 22'h2AAAAA, CS low, 24 master clocks at clk/8 → MISO sequence 0,0, then 1,0,1,0…; frame_done pulses once; sample_ready returns to 1 after the CS fall.
- After that frame, a second frame with no load → same 24 bits repeated and stale=1. Then load 22'h000001 → next frame ends in …0,1 and stale=0.
- CS rises after 10 clocks → frame_abort pulses, no frame_done, MISO=1; the next frame without a load repeats the aborted sample.
- Load 22'h3FFFFF with valid held in the same cycle as the synchronised CS fall, holding empty → frame sends the old last value, and the new sample is served in the following frame.
- Assert rst at bit 12 → MISO=1 and sample_ready=1 immediately; a subsequent frame sends 24 zeros with stale=1.
- With ADC_DRDY_EN defined: CS low, no sample for 50 clk → MISO stays 1. Load 22'h155555 → MISO pulses 0, then the frame outputs 00 followed by 0101…01.
